// File: rtl/snek_game_ctrl_if.sv
`timescale 1ns/1ps
// Bundle between the snek game sequencer and the rest of the top level:
// button/snake status in, phase, direction, tick and score out.
interface snek_game_ctrl_if;
    logic [3:0] buttons;
    logic [7:0] snek_len;
    logic       ate;
    logic       dead;
    logic       frame_tick;
    logic [1:0] dir;
    logic       game_rst;
    logic       run;
    logic       splash_en;
    logic       flash;
    logic [7:0] score;
    logic [7:0] hiscore;
    logic [1:0] state;

    modport master (
        output buttons, snek_len, ate, dead,
        input  frame_tick, dir, game_rst, run, splash_en, flash, score, hiscore, state
    );

    modport slave (
        input  buttons, snek_len, ate, dead,
        output frame_tick, dir, game_rst, run, splash_en, flash, score, hiscore, state
    );
endinterface

// File: rtl/snek_game_ctrl.sv
`timescale 1ns/1ps
// Snek game sequencer: splash/play/dying/over phases, speed-scaled frame tick,
// game reset pulse and a two-deep filtered direction command queue.
module snek_game_ctrl #(
    parameter int unsigned MS_CYCLES   = 12500,
    parameter int unsigned SPLASH_MS   = 10000,
    parameter int unsigned TICK_BASE   = 6250000,
    parameter int unsigned TICK_STEP   = 200000,
    parameter int unsigned TICK_MIN    = 1000000,
    parameter int unsigned FLASH_TICKS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    snek_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_SPLASH = 2'd0,
        ST_PLAY   = 2'd1,
        ST_DYING  = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  q_mem_q [2];
    logic [1:0]  q_mem_d [2];
    logic [1:0]  q_cnt_q, q_cnt_d;
    logic [3:0]  btn_prev_q, btn_prev_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] ms_cyc_q, ms_cyc_d;
    logic [31:0] ms_cnt_q, ms_cnt_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  hiscore_q, hiscore_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;
    logic        flash_q, flash_d;
    logic        holdoff_q, holdoff_d;
    logic        game_rst_q, game_rst_d;
    logic        run_q, run_d;
    logic        splash_en_q, splash_en_d;

    logic [3:0]  rise;
    logic        press_any;
    logic [1:0]  press_dir;
    logic        tick;
    logic [31:0] step_prod;
    logic [31:0] period_calc;
    logic        start;
    logic        ms_wrap;
    logic [1:0]  pq_mem [2];
    logic [1:0]  pq_cnt;
    logic [1:0]  pdir;
    logic [1:0]  ref_dir;
    logic        accept;

    // Only one press per cycle: left > right > up > down.
    always_comb begin
        rise      = bus.buttons & ~btn_prev_q;
        press_any = |rise;
        if (rise[1])      press_dir = 2'd0;
        else if (rise[0]) press_dir = 2'd1;
        else if (rise[2]) press_dir = 2'd2;
        else              press_dir = 2'd3;
    end

    always_comb begin
        step_prod = TICK_STEP * 32'(bus.snek_len);
        if (step_prod >= TICK_BASE || (TICK_BASE - step_prod) < TICK_MIN)
            period_calc = TICK_MIN;
        else
            period_calc = TICK_BASE - step_prod;
        tick       = (tick_cnt_q == period_q - 32'd1);
        tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
        period_d   = tick ? period_calc : period_q;
        btn_prev_d = bus.buttons;
    end

    // Pop first, then filter the press against the post-pop tail or dir.
    always_comb begin
        pq_mem = q_mem_q;
        pq_cnt = q_cnt_q;
        pdir   = dir_q;
        if (tick && q_cnt_q != 2'd0) begin
            pdir      = q_mem_q[0];
            pq_mem[0] = q_mem_q[1];
            pq_cnt    = q_cnt_q - 2'd1;
        end
        if (pq_cnt == 2'd2)      ref_dir = pq_mem[1];
        else if (pq_cnt == 2'd1) ref_dir = pq_mem[0];
        else                     ref_dir = pdir;
        accept = press_any && (pq_cnt != 2'd2) && (press_dir != ref_dir)
                 && (press_dir != (ref_dir ^ 2'd1));
        if (accept) begin
            if (pq_cnt == 2'd0) pq_mem[0] = press_dir;
            else                pq_mem[1] = press_dir;
            pq_cnt = pq_cnt + 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        q_mem_d     = q_mem_q;
        q_cnt_d     = q_cnt_q;
        score_d     = score_q;
        hiscore_d   = hiscore_q;
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        ms_cyc_d    = ms_cyc_q;
        ms_cnt_d    = ms_cnt_q;
        holdoff_d   = holdoff_q;
        game_rst_d  = 1'b0;
        start       = 1'b0;
        ms_wrap     = (ms_cyc_q == MS_CYCLES - 1);

        case (state_q)
            ST_SPLASH: begin
                ms_cyc_d = ms_wrap ? 32'd0 : ms_cyc_q + 32'd1;
                if (ms_wrap) ms_cnt_d = ms_cnt_q + 32'd1;
                if (press_any || (ms_wrap && ms_cnt_q == SPLASH_MS - 1)) start = 1'b1;
            end
            ST_PLAY: begin
                dir_d   = pdir;
                q_mem_d = pq_mem;
                q_cnt_d = pq_cnt;
                if (bus.ate && score_q != 8'hFF) score_d = score_q + 8'd1;
                if (bus.dead) begin
                    state_d     = ST_DYING;
                    flash_d     = 1'b1;
                    flash_cnt_d = 8'd0;
                end
            end
            ST_DYING: begin
                if (flash_cnt_q == 8'(FLASH_TICKS)) begin
                    state_d   = ST_OVER;
                    flash_d   = 1'b0;
                    holdoff_d = 1'b1;
                    if (score_q > hiscore_q) hiscore_d = score_q;
                end else if (tick) begin
                    flash_d     = ~flash_q;
                    flash_cnt_d = flash_cnt_q + 8'd1;
                end
            end
            ST_OVER: begin
                if (tick) holdoff_d = 1'b0;
                if (press_any && !holdoff_q) start = 1'b1;
            end
            default: state_d = ST_SPLASH;
        endcase

        if (start) begin
            state_d    = ST_PLAY;
            game_rst_d = 1'b1;
            score_d    = 8'd0;
            dir_d      = 2'd0;
            q_cnt_d    = 2'd0;
            ms_cyc_d   = 32'd0;
            ms_cnt_d   = 32'd0;
            holdoff_d  = 1'b0;
        end

        run_d       = (state_d == ST_PLAY);
        splash_en_d = (state_d == ST_SPLASH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SPLASH;
            dir_q       <= 2'd0;
            q_mem_q[0]  <= 2'd0;
            q_mem_q[1]  <= 2'd0;
            q_cnt_q     <= 2'd0;
            btn_prev_q  <= 4'd0;
            tick_cnt_q  <= 32'd0;
            period_q    <= TICK_BASE;
            ms_cyc_q    <= 32'd0;
            ms_cnt_q    <= 32'd0;
            score_q     <= 8'd0;
            hiscore_q   <= 8'd0;
            flash_cnt_q <= 8'd0;
            flash_q     <= 1'b0;
            holdoff_q   <= 1'b0;
            game_rst_q  <= 1'b0;
            run_q       <= 1'b0;
            splash_en_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            q_mem_q     <= q_mem_d;
            q_cnt_q     <= q_cnt_d;
            btn_prev_q  <= btn_prev_d;
            tick_cnt_q  <= tick_cnt_d;
            period_q    <= period_d;
            ms_cyc_q    <= ms_cyc_d;
            ms_cnt_q    <= ms_cnt_d;
            score_q     <= score_d;
            hiscore_q   <= hiscore_d;
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
            holdoff_q   <= holdoff_d;
            game_rst_q  <= game_rst_d;
            run_q       <= run_d;
            splash_en_q <= splash_en_d;
        end
    end

    assign bus.frame_tick = tick;
    assign bus.dir        = dir_q;
    assign bus.game_rst   = game_rst_q;
    assign bus.run        = run_q;
    assign bus.splash_en  = splash_en_q;
    assign bus.flash      = flash_q;
    assign bus.score      = score_q;
    assign bus.hiscore    = hiscore_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_snek_game_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for snek_game_ctrl: stimulus queues expected tick and
// game_rst responses, a negedge monitor pops and compares them.
module tb_snek_game_ctrl;
    localparam int unsigned MS_CYCLES   = 4;
    localparam int unsigned SPLASH_MS   = 5;
    localparam int unsigned TICK_BASE   = 100;
    localparam int unsigned TICK_STEP   = 10;
    localparam int unsigned TICK_MIN    = 30;
    localparam int unsigned FLASH_TICKS = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snek_game_ctrl_if bus();

    snek_game_ctrl #(
        .MS_CYCLES(MS_CYCLES), .SPLASH_MS(SPLASH_MS), .TICK_BASE(TICK_BASE),
        .TICK_STEP(TICK_STEP), .TICK_MIN(TICK_MIN), .FLASH_TICKS(FLASH_TICKS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int spacing; int dir; int state; int flash; int score; int hiscore;
    } tick_exp_t;
    typedef struct {
        int score; int dir; int hiscore; int cyc_lo; int cyc_hi;
    } rst_exp_t;

    tick_exp_t tick_q[$];
    rst_exp_t  rst_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rel0 = 0;
    int n_tick = 0;
    int n_rst = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: tick fields are sampled one cycle after the tick so the
    // effect of the tick (pop, flash toggle, phase change) is visible.
    initial begin : monitor
        tick_exp_t e;
        rst_exp_t  r;
        int last_tick;
        int pend_sp;
        bit pend;
        last_tick = -1;
        pend = 1'b0;
        pend_sp = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                last_tick = -1;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (tick_q.size() > 0) begin
                        e = tick_q.pop_front();
                        n_tick++;
                        $display("tick %0d: spacing=%0d dir=%0d state=%0d flash=%0d score=%0d hiscore=%0d",
                                 n_tick, pend_sp, bus.dir, bus.state, bus.flash, bus.score, bus.hiscore);
                        if (e.spacing >= 0) check("tick_spacing", pend_sp, e.spacing);
                        if (e.dir >= 0)     check("tick_dir", int'(bus.dir), e.dir);
                        if (e.state >= 0)   check("tick_state", int'(bus.state), e.state);
                        if (e.flash >= 0)   check("tick_flash", int'(bus.flash), e.flash);
                        if (e.score >= 0)   check("tick_score", int'(bus.score), e.score);
                        if (e.hiscore >= 0) check("tick_hiscore", int'(bus.hiscore), e.hiscore);
                    end
                end
                if (bus.frame_tick) begin
                    pend = 1'b1;
                    pend_sp = (last_tick < 0) ? -1 : cyc - last_tick;
                    last_tick = cyc;
                end
                if (bus.game_rst) begin
                    if (rst_q.size() == 0) begin
                        check("unexpected_game_rst", 1, 0);
                    end else begin
                        r = rst_q.pop_front();
                        n_rst++;
                        $display("game_rst %0d: cyc=%0d state=%0d run=%0d score=%0d dir=%0d hiscore=%0d",
                                 n_rst, cyc - rel0, bus.state, bus.run, bus.score, bus.dir, bus.hiscore);
                        check("rst_state", int'(bus.state), 1);
                        check("rst_run", int'(bus.run), 1);
                        check("rst_splash_en", int'(bus.splash_en), 0);
                        check("rst_score", int'(bus.score), r.score);
                        check("rst_dir", int'(bus.dir), r.dir);
                        check("rst_hiscore", int'(bus.hiscore), r.hiscore);
                        if (r.cyc_lo >= 0)
                            check("rst_cycle_window",
                                  int'((cyc - rel0) >= r.cyc_lo && (cyc - rel0) <= r.cyc_hi), 1);
                    end
                end
            end
        end
    end

    task automatic expect_tick(input int sp, input int d, input int s, input int f,
                               input int sc, input int hs);
        tick_exp_t e;
        e.spacing = sp; e.dir = d; e.state = s; e.flash = f; e.score = sc; e.hiscore = hs;
        tick_q.push_back(e);
        for (int i = 0; i < 400 && tick_q.size() > 0; i++) @(posedge clk);
        if (tick_q.size() > 0) begin
            check("tick_timeout", 0, 1);
            tick_q.delete();
        end
    endtask

    task automatic push_rst(input int sc, input int d, input int hs, input int lo, input int hi);
        rst_exp_t r;
        r.score = sc; r.dir = d; r.hiscore = hs; r.cyc_lo = lo; r.cyc_hi = hi;
        rst_q.push_back(r);
    endtask

    task automatic wait_rst();
        for (int i = 0; i < 200 && rst_q.size() > 0; i++) @(posedge clk);
        if (rst_q.size() > 0) begin
            check("game_rst_timeout", 0, 1);
            rst_q.delete();
        end
    endtask

    task automatic press(input int idx);
        @(posedge clk); #1;
        bus.buttons[idx] = 1'b1;
        @(posedge clk); #1;
        bus.buttons = 4'd0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_ate();
        @(posedge clk); #1 bus.ate = 1'b1;
        @(posedge clk); #1 bus.ate = 1'b0;
    endtask

    task automatic pulse_dead();
        @(posedge clk); #1 bus.dead = 1'b1;
        @(posedge clk); #1 bus.dead = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rel0 = cyc;
    endtask

    task automatic check_reset_values(input string tag);
        $display("reset check %s: state=%0d dir=%0d score=%0d hiscore=%0d flash=%0d",
                 tag, bus.state, bus.dir, bus.score, bus.hiscore, bus.flash);
        check({tag, "_state"}, int'(bus.state), 0);
        check({tag, "_dir"}, int'(bus.dir), 0);
        check({tag, "_score"}, int'(bus.score), 0);
        check({tag, "_hiscore"}, int'(bus.hiscore), 0);
        check({tag, "_flash"}, int'(bus.flash), 0);
        check({tag, "_run"}, int'(bus.run), 0);
        check({tag, "_splash_en"}, int'(bus.splash_en), 1);
        check({tag, "_game_rst"}, int'(bus.game_rst), 0);
        check({tag, "_frame_tick"}, int'(bus.frame_tick), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.buttons = 4'd0;
        bus.snek_len = 8'd0;
        bus.ate = 1'b0;
        bus.dead = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("por");

        // Auto-start: 5 ms of 4 cycles each puts PLAY about 20 cycles in.
        push_rst(0, 0, 0, 18, 22);
        release_reset();
        wait_rst();
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("play_rst");

        // Splash skip by button, then direction filtering in PLAY.
        release_reset();
        repeat (3) @(posedge clk);
        push_rst(0, 0, 0, -1, -1);
        press(0);
        wait_rst();
        press(0);   // right: reverse of dir=0
        press(2);   // up: queued
        press(1);   // left: queued behind up
        press(3);   // down: queue full
        expect_tick(-1, 2, 1, 0, 0, 0);
        expect_tick(100, 0, 1, -1, -1, -1);
        expect_tick(100, 0, 1, -1, -1, -1);

        // Speed scaling; the new period applies from the period after the change.
        repeat (10) @(posedge clk);
        #1 bus.snek_len = 8'd5;
        expect_tick(100, -1, 1, -1, -1, -1);
        expect_tick(50, -1, 1, -1, -1, -1);
        repeat (10) @(posedge clk);
        #1 bus.snek_len = 8'd20;
        expect_tick(50, -1, 1, -1, -1, -1);
        expect_tick(30, -1, 1, -1, -1, -1);
        repeat (5) @(posedge clk);
        #1 bus.snek_len = 8'd255;
        expect_tick(30, -1, 1, -1, -1, -1);
        expect_tick(30, -1, 1, -1, -1, -1);

        // Death: three foods, collision, six flash toggles, then OVER.
        repeat (2) @(posedge clk);
        pulse_ate();
        pulse_ate();
        pulse_ate();
        pulse_dead();
        expect_tick(30, -1, 2, 0, 3, 0);
        expect_tick(30, -1, 2, 1, 3, 0);
        pulse_ate();
        pulse_dead();
        expect_tick(30, -1, 2, 0, 3, 0);
        expect_tick(30, -1, 2, 1, 3, 0);
        expect_tick(30, -1, 2, 0, 3, 0);
        expect_tick(30, -1, 2, 1, 3, 0);
        repeat (3) @(posedge clk);
        press(2);   // inside the OVER holdoff: no game_rst expected
        expect_tick(30, -1, 3, 0, 3, 3);
        push_rst(0, 0, 3, -1, -1);
        press(1);
        wait_rst();

        // Async reset while DYING.
        pulse_ate();
        pulse_dead();
        repeat (2) @(posedge clk);
        #1 check("pre_reset_state", int'(bus.state), 2);
        check("pre_reset_score", int'(bus.score), 1);
        check("pre_reset_hiscore", int'(bus.hiscore), 3);
        #2 rst_n = 1'b0;
        #1 check_reset_values("dying_rst");

        // Score saturation over 300 foods.
        release_reset();
        repeat (3) @(posedge clk);
        push_rst(0, 0, 0, -1, -1);
        press(0);
        wait_rst();
        for (int i = 0; i < 300; i++) pulse_ate();
        expect_tick(-1, -1, 1, 0, 255, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snek_game_ctrl.md
Name: snek_game_ctrl

Overview:
Top-level game sequencer for snek. It owns the splash, play, dying and game-over phases, and generates the speed-scaled frame tick that drives snake motion. It also issues the game reset pulse and queues filtered direction commands from the buttons. It sits between the button inputs and the snake/food generators, replacing the ad-hoc state, clock-divider and direction logic in the top level.

Parameters:
MS_CYCLES, 12500, clk cycles per millisecond tick
SPLASH_MS, 10000, splash duration in ms before auto-start
TICK_BASE, 6250000, frame period in clk cycles at snek_len=0
TICK_STEP, 200000, period reduction per unit of snek_len
TICK_MIN, 1000000, lower bound on the frame period (clk cycles)
FLASH_TICKS, 6, frame ticks spent in DYING

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
buttons  in  4  raw level, synchronous to clk; [0]=right [1]=left [2]=up [3]=down
snek_len  in  8  current body length from the snake generator
ate  in  1  1-clk pulse: head reached food
dead  in  1  level: snake collision
frame_tick  out  1  1-clk pulse, once per frame period
dir  out  2  0=left 1=right 2=up 3=down; the applied direction
game_rst  out  1  1-clk pulse resetting the snake and food generators
run  out  1  high only in PLAY
splash_en  out  1  high only in SPLASH
flash  out  1  death blink, valid in DYING, 0 elsewhere
score  out  8  foods eaten this game
hiscore  out  8  best score since rst_n
state  out  2  0=SPLASH 1=PLAY 2=DYING 3=OVER

Behaviour:
- Reset (async, rst_n=0): state=SPLASH, dir=0, queue empty, score=0, hiscore=0, flash=0, game_rst=0, frame_tick=0, all counters=0.
- Button press: a rising edge of buttons[i], detected against the previous-cycle sample register. If several edges occur in the same cycle, priority is left > right > up > down, and only one press is taken.
- Direction queue: 2 entries. Each press is compared against a reference direction, which is the queue tail if the queue is non-empty, else dir.
  - A press is accepted only in PLAY.
  - It is rejected if it equals the reference or is the reverse of it (0<->1, 2<->3).
  - If the queue is full, the press is dropped.
- Queue pop: on frame_tick in PLAY with a non-empty queue, the head moves to dir in the same cycle.
  - If a press and a pop happen in the same cycle, the pop happens first and the press is compared against the post-pop tail (or the new dir if the queue is now empty).
  - Entering PLAY clears the queue and sets dir=0.
- Frame period: P = max(TICK_BASE - TICK_STEP*snek_len, TICK_MIN), computed at 32 bits. A subtraction underflow yields TICK_MIN.
  - P is latched when frame_tick fires, so mid-period changes to snek_len take effect on the next period.
  - The counter runs from 0 to P-1. frame_tick=1 on the cycle the count equals P-1, and the counter returns to 0.
  - The first tick after reset comes TICK_BASE cycles after reset release.
  - The counter runs in all states.
- ms counter: 0..MS_CYCLES-1, with a wrap pulse; it counts only in SPLASH.
- SPLASH -> PLAY: when the ms count reaches SPLASH_MS, or on any button rising edge.
  - game_rst pulses for 1 clk in the transition cycle; score is cleared.
  - The ms count clears on exit.
- PLAY:
  - An ate pulse increments score, saturating at 255.
  - dead=1 -> DYING on the next clk; flash=1 and the flash count is set to 0.
  - If ate and dead occur in the same cycle, the score still increments.
- DYING: each frame_tick toggles flash and increments the flash count. When the count reaches FLASH_TICKS: go to OVER, flash=0, and set hiscore=score if score>hiscore (same clk edge).
- OVER: a button rising edge causes game_rst to pulse 1 clk, score=0 and a move to PLAY. Edges during the first frame_tick period after entering OVER are ignored (an anti-bounce holdoff, tracked by a flag cleared on the next frame_tick).
- ate and dead are ignored outside PLAY.
- Outputs run, splash_en and state are registered and decoded from the state register.
- rst_n asserted mid-game returns all of the above to reset values immediately. hiscore is lost.

Test Plan:
- Splash auto-start (MS_CYCLES=4, SPLASH_MS=5, no buttons) -> exactly one game_rst pulse; state 0->1 at ~20 clk after reset release; run=1.
- Splash skip: pulse buttons[0] in SPLASH -> game_rst next edge, state=1, dir=0, score=0.
- Direction filter: in PLAY with dir=0, press right(1) -> rejected. Press up(2), then left(0) before a tick -> queue holds 2,0. Next two ticks give dir=2 then dir=0. A third press while the queue is full is dropped.
- Speed (TICK_BASE=100, TICK_STEP=10, TICK_MIN=30): snek_len=0 gives 100-clk spacing; snek_len=5 gives 50 from the period after the change; snek_len=20 gives 30 (floor, no underflow).
- Death sequence (FLASH_TICKS=6): 3 ate pulses, then dead -> score=3, state=2, flash toggles 6 times, then state=3, hiscore=3, flash=0. A button within the holdoff is ignored; a button after it gives game_rst and score=0.
- Async reset mid-DYING -> all outputs at reset values without a clock edge; hiscore=0; score saturates at 255 after 300 ate pulses in a separate run.
